// File: rtl/mips_avalon_master.sv
// mips_avalon_master
//   Bridges the MIPS load/store port onto an Avalon-MM master. One request
//   is in flight at a time. Byte/half/word requests become a single aligned
//   word access with byteenable; load results are lane-extracted and sign-
//   or zero-extended. Misaligned requests and waitrequest timeouts come back
//   to the CPU as cpu_err alongside the cpu_done pulse.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cpu_req .. cpu_wdata   CPU request (sampled only in IDLE)
//   cpu_stall         combinational cpu_req & ~cpu_done
//   cpu_done/err/rdata     registered one-cycle response
//   avm_*             Avalon-MM master (registered outputs)
//
// Parameter
//   TIMEOUT_CYCLES    waitrequest-high cycles tolerated; 0 = never time out

module mips_avalon_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Counter just wide enough to hold TIMEOUT_CYCLES.
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

    // Fields of the accepted request still needed when read data returns.
    typedef struct packed {
        logic       we;
        logic [1:0] off;
        logic [1:0] size;
        logic       sgn;
    } req_t;

    logic [1:0]    state;
    req_t          req_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          timeout;

    logic          misaligned;
    logic [3:0]    be_n;
    logic [31:0]   wd_n;
    logic [31:0]   lane_w;
    logic [31:0]   rd_n;

    assign cpu_stall = cpu_req & ~cpu_done;

    // Request decode: alignment check, byte lanes and lane-replicated data.
    always_comb begin
        misaligned = 1'b0;
        be_n       = 4'b0000;
        wd_n       = 32'd0;
        case (cpu_size)
            2'b00: begin
                be_n = 4'b0001 << cpu_addr[1:0];
                wd_n = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = cpu_addr[0];
                be_n       = cpu_addr[1] ? 4'b1100 : 4'b0011;
                wd_n       = {2{cpu_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = |cpu_addr[1:0];
                be_n       = 4'b1111;
                wd_n       = cpu_wdata;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Load return: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        lane_w = avm_readdata >> {req_q.off, 3'b000};
        case (req_q.size)
            2'b00:   rd_n = req_q.sgn ? {{24{lane_w[7]}},  lane_w[7:0]}
                                      : {24'd0, lane_w[7:0]};
            2'b01:   rd_n = req_q.sgn ? {{16{lane_w[15]}}, lane_w[15:0]}
                                      : {16'd0, lane_w[15:0]};
            default: rd_n = avm_readdata;
        endcase
    end

    assign cnt_nxt = cnt + 1'b1;
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_nxt == TO_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            req_q          <= '0;
            cnt            <= '0;
            cpu_done       <= 1'b0;
            cpu_err        <= 1'b0;
            cpu_rdata      <= 32'd0;
            avm_address    <= 32'd0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 32'd0;
            avm_byteenable <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    cpu_done <= 1'b0;
                    cpu_err  <= 1'b0;
                    if (cpu_req) begin
                        if (misaligned) begin
                            // Rejected without touching the bus.
                            cpu_done  <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= 32'd0;
                            state     <= S_RESP;
                        end else begin
                            req_q.we       <= cpu_we;
                            req_q.off      <= cpu_addr[1:0];
                            req_q.size     <= cpu_size;
                            req_q.sgn      <= cpu_signed;
                            avm_address    <= {cpu_addr[31:2], 2'b00};
                            avm_byteenable <= be_n;
                            avm_writedata  <= cpu_we ? wd_n : 32'd0;
                            avm_read       <= ~cpu_we;
                            avm_write      <= cpu_we;
                            cnt            <= '0;
                            state          <= S_ACCESS;
                        end
                    end
                end

                S_ACCESS: begin
                    // avm_* stay untouched here until the access ends.
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        cnt       <= '0;
                        cpu_done  <= 1'b1;
                        cpu_err   <= 1'b0;
                        cpu_rdata <= req_q.we ? 32'd0 : rd_n;
                        state     <= S_RESP;
                    end else if (timeout) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        cnt       <= '0;
                        cpu_done  <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= 32'd0;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end

                S_RESP: begin
                    // Response is presented for exactly this one cycle.
                    cpu_done <= 1'b0;
                    cpu_err  <= 1'b0;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_avalon_master.sv
module tb_mips_avalon_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_signed;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_avalon_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_size(cpu_size), .cpu_signed(cpu_signed), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] srd;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        int          e_strobes;
        int          e_cycles;
    } vec_t;

    typedef struct {
        logic        done;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rd_seen, wr_seen;
        int          strobes, cycles;
        logic        stable, stall_ok, single;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Spec-level reference: byte count, lane shift and replication by arithmetic.
    task automatic model(inout vec_t v);
        int nb, off;
        logic mis, tmo;
        logic [31:0] mask, val;
        off  = int'(v.addr % 4);
        nb   = 1 << v.size;
        mis  = (v.size == 3) || (v.size == 1 && off % 2 != 0) || (v.size == 2 && off != 0);
        tmo  = !mis && v.waits >= TO;
        v.e_err  = mis | tmo;
        v.e_addr = v.addr - 32'(off);
        v.e_be   = (v.size == 3) ? 4'd0 : 4'(((1 << nb) - 1) << off);
        v.e_wd   = 0;
        for (int i = 0; i < 4; i++)
            v.e_wd[8*i +: 8] = v.wdata[8*(i % nb) +: 8];
        mask = (nb >= 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8*nb)) - 1);
        val  = (v.srd >> (8*off)) & mask;
        if (v.sgn && nb < 4 && val[8*nb-1]) val = val | ~mask;
        v.e_rdata   = (mis || tmo || v.we) ? 32'd0 : val;
        v.e_strobes = mis ? 0 : (tmo ? TO : v.waits + 1);
        v.e_cycles  = mis ? 1 : (tmo ? TO + 1 : v.waits + 2);
    endtask

    // Drives one request and plays a slave holding waitrequest for 'waits'
    // strobe cycles. Called just after a negedge with the DUT idle.
    task automatic run_txn(input vec_t v, output res_t r);
        r = '{default: 0};
        r.stable = 1; r.stall_ok = 1; r.single = 1;
        cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_size = v.size;
        cpu_signed = v.sgn; cpu_wdata = v.wdata;
        avm_readdata = v.srd; avm_waitrequest = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (avm_read || avm_write) begin
                r.strobes++;
                if (r.strobes == 1) begin
                    r.addr = avm_address; r.be = avm_byteenable; r.wd = avm_writedata;
                    r.rd_seen = avm_read; r.wr_seen = avm_write;
                end else if (avm_address !== r.addr || avm_byteenable !== r.be ||
                             avm_writedata !== r.wd || avm_read !== r.rd_seen ||
                             avm_write !== r.wr_seen) r.stable = 0;
                avm_waitrequest = (r.strobes <= v.waits);
            end
            if (cpu_stall !== !cpu_done) r.stall_ok = 0;
            if (cpu_done) begin
                r.done = 1; r.err = cpu_err; r.rdata = cpu_rdata; r.cycles = c;
                break;
            end
        end
        cpu_req = 0; avm_waitrequest = 0;
        @(negedge clk);
        if (cpu_done !== 1'b0) r.single = 0;
    endtask

    task automatic compare(input string tag, input vec_t v, input res_t r);
        chk({tag, " done"}, 32'(r.done), 32'd1);
        chk({tag, " cycles"}, r.cycles, v.e_cycles);
        chk({tag, " err"}, 32'(r.err), 32'(v.e_err));
        chk({tag, " rdata"}, r.rdata, v.e_rdata);
        chk({tag, " strobes"}, r.strobes, v.e_strobes);
        chk({tag, " single_done"}, 32'(r.single), 32'd1);
        chk({tag, " stall"}, 32'(r.stall_ok), 32'd1);
        if (v.e_strobes > 0) begin
            chk({tag, " addr"}, r.addr, v.e_addr);
            chk({tag, " be"}, 32'(r.be), 32'(v.e_be));
            chk({tag, " dir"}, {30'd0, r.wr_seen, r.rd_seen}, {30'd0, v.we, !v.we});
            chk({tag, " held"}, 32'(r.stable), 32'd1);
            if (v.we) chk({tag, " wdata"}, r.wd, v.e_wd);
        end
    endtask

    vec_t vecs[13];
    vec_t v;
    res_t r;
    int   n_strobe;
    logic saw_done;

    function automatic vec_t mk(logic we, logic [31:0] a, logic [1:0] sz, logic sg,
                                logic [31:0] wd, int w, logic [31:0] srd, logic ee,
                                logic [31:0] er, logic [31:0] ea, logic [3:0] eb,
                                logic [31:0] ew, int es, int ec);
        vec_t t;
        t.we = we; t.addr = a; t.size = sz; t.sgn = sg; t.wdata = wd; t.waits = w;
        t.srd = srd; t.e_err = ee; t.e_rdata = er; t.e_addr = ea; t.e_be = eb;
        t.e_wd = ew; t.e_strobes = es; t.e_cycles = ec;
        return t;
    endfunction

    initial begin
        // Hand-derived expectations.
        vecs[0]  = mk(0, 32'hBFC00010, 2, 0, 0, 2, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'hBFC00010, 4'hF, 0, 3, 4);
        vecs[1]  = mk(1, 32'hBFC00006, 0, 0, 32'hA5, 0, 0, 0, 0, 32'hBFC00004, 4'h4, 32'hA5A5A5A5, 1, 2);
        vecs[2]  = mk(0, 32'hBFC00002, 1, 1, 0, 0, 32'h8001FFFF, 0, 32'hFFFF8001, 32'hBFC00000, 4'hC, 0, 1, 2);
        vecs[3]  = mk(0, 32'hBFC00002, 1, 0, 0, 1, 32'h8001FFFF, 0, 32'h00008001, 32'hBFC00000, 4'hC, 0, 2, 3);
        vecs[4]  = mk(0, 32'hBFC00001, 2, 0, 0, 0, 32'h11111111, 1, 0, 0, 0, 0, 0, 1);
        vecs[5]  = mk(0, 32'hBFC00020, 2, 0, 0, 9, 32'h12345678, 1, 0, 32'hBFC00020, 4'hF, 0, 4, 5);
        vecs[6]  = mk(1, 32'h00000102, 1, 0, 32'hFFFF1234, 1, 0, 0, 0, 32'h00000100, 4'hC, 32'h12341234, 2, 3);
        vecs[7]  = mk(0, 32'h00000000, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        vecs[8]  = mk(0, 32'h00000013, 0, 1, 0, 0, 32'h80FF7F01, 0, 32'hFFFFFF80, 32'h00000010, 4'h8, 0, 1, 2);
        vecs[9]  = mk(0, 32'h00000011, 0, 0, 0, 0, 32'h80FF7F01, 0, 32'h0000007F, 32'h00000010, 4'h2, 0, 1, 2);
        vecs[10] = mk(1, 32'h00000040, 2, 0, 32'hCAFEF00D, 3, 0, 0, 0, 32'h00000040, 4'hF, 32'hCAFEF00D, 4, 5);
        vecs[11] = mk(0, 32'h00000201, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        vecs[12] = mk(1, 32'h00000300, 2, 0, 32'h55AA55AA, 4, 0, 1, 0, 32'h00000300, 4'hF, 32'h55AA55AA, 4, 5);

        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_size = 0;
        cpu_signed = 0; cpu_wdata = 0; avm_waitrequest = 0; avm_readdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outs", {avm_read, avm_write, cpu_done, cpu_err, avm_byteenable},
            8'd0);
        chk("reset addr", avm_address, 0);
        chk("reset wdata", avm_writedata, 0);
        chk("reset rdata", cpu_rdata, 0);
        rst = 0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_txn(vecs[i], r);
            compare($sformatf("vec%0d", i), vecs[i], r);
        end

        // Reset during the 2nd wait cycle of a write, with waitrequest falling.
        v = mk(1, 32'h00000080, 2, 0, 32'h0BADF00D, 20, 0, 0, 0, 0, 0, 0, 0, 0);
        cpu_req = 1; cpu_we = 1; cpu_addr = v.addr; cpu_size = 2; cpu_wdata = v.wdata;
        avm_waitrequest = 1;
        n_strobe = 0;
        for (int c = 0; c < 20 && n_strobe < 2; c++) begin
            @(negedge clk);
            if (avm_write) n_strobe++;
        end
        chk("rst_mid strobes", n_strobe, 2);
        rst = 1; avm_waitrequest = 0;
        @(negedge clk);
        chk("rst_mid write", 32'(avm_write), 0);
        chk("rst_mid done", 32'(cpu_done), 0);
        chk("rst_mid be", 32'(avm_byteenable), 0);
        rst = 0; cpu_req = 0;
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_done || avm_write || avm_read) saw_done = 1;
        end
        chk("rst_mid quiet", 32'(saw_done), 0);
        v = mk(0, 32'h00000084, 2, 0, 0, 1, 32'h600DCAFE, 0, 0, 0, 0, 0, 0, 0);
        model(v);
        run_txn(v, r);
        compare("post_rst", v, r);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.we    = 1'($urandom);
            v.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            v.addr  = $urandom;
            if ($urandom_range(0, 3) != 0)
                v.addr = v.addr & ~((32'd1 << v.size) - 1);
            v.sgn   = 1'($urandom);
            v.wdata = $urandom;
            v.srd   = $urandom;
            v.waits = ($urandom_range(0, 7) == 0) ? 4 + $urandom_range(0, 2)
                                                  : $urandom_range(0, 3);
            model(v);
            run_txn(v, r);
            compare($sformatf("rnd%0d", i), v, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
